// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the common data bus arbiter: default widths and requester indices.
package cdb_arbiter_pkg;

  localparam int unsigned TAG_WIDTH   = 6;
  localparam int unsigned DATA_WIDTH  = 32;
  localparam int unsigned CDB_NUM_REQ = 3;

  typedef enum logic [1:0] {
    CDB_SRC_ALU    = 2'd0,
    CDB_SRC_LS     = 2'd1,
    CDB_SRC_BRANCH = 2'd2
  } cdb_src_e;

  localparam logic [TAG_WIDTH-1:0] TAG_FREE = '0;

  // Reduces idx (< 2*n) modulo n without a divider.
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? idx - n : idx;
  endfunction

endpackage

// File: rtl/cdb_req_fifo.sv
// Per-requester result FIFO of {tag, data}; power-of-two depth, flush clears all state.
module cdb_req_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned TAG_W  = TAG_WIDTH,
  parameter int unsigned DATA_W = DATA_WIDTH,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [TAG_W-1:0]  push_tag,
  input  logic [DATA_W-1:0] push_data,
  output logic [TAG_W-1:0]  head_tag,
  output logic [DATA_W-1:0] head_data,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign full   = (r_count == CNT_W'(DEPTH));
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  assign head_tag  = r_tag[r_rd_ptr];
  assign head_data = r_data[r_rd_ptr];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst && !flush) begin
      r_tag[r_wr_ptr]  <= push_tag;
      r_data[r_wr_ptr] <= push_data;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered result broadcast among queued execution units.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = CDB_NUM_REQ,
  parameter int unsigned TAG_W      = TAG_WIDTH,
  parameter int unsigned DATA_W     = DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned SRC_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*TAG_W-1:0]  in_tag,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      cdb_en,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [TAG_W-1:0]   w_head_tag  [NUM_REQ];
  logic [DATA_W-1:0]  w_head_data [NUM_REQ];
  logic [CNT_W-1:0]   w_count     [NUM_REQ];
  logic [NUM_REQ-1:0] w_full;
  logic [NUM_REQ-1:0] w_empty;
  logic [NUM_REQ-1:0] w_pop;

  logic               w_gnt_valid;
  logic [SRC_W-1:0]   w_gnt;
  logic [SRC_W-1:0]   w_rr_next;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [DATA_W-1:0]  w_sel_data;

  logic               r_en;
  logic [TAG_W-1:0]   r_tag;
  logic [DATA_W-1:0]  r_data;
  logic [SRC_W-1:0]   r_src;
  logic [SRC_W-1:0]   r_rr_ptr;

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_fifo
    // Ready comes from the registered count only, so a full FIFO refuses even when popped.
    assign in_ready[k] = (w_count[k] < CNT_W'(FIFO_DEPTH));
    assign w_pop[k]    = w_gnt_valid && (w_gnt == SRC_W'(k));

    cdb_req_fifo #(
      .TAG_W  (TAG_W),
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (in_valid[k] && !w_full[k]),
      .pop       (w_pop[k]),
      .push_tag  (in_tag[k*TAG_W +: TAG_W]),
      .push_data (in_data[k*DATA_W +: DATA_W]),
      .head_tag  (w_head_tag[k]),
      .head_data (w_head_data[k]),
      .count     (w_count[k]),
      .full      (w_full[k]),
      .empty     (w_empty[k])
    );
  end

  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_sel_tag   = '0;
    w_sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      int unsigned idx;
      idx = rr_wrap(int'(r_rr_ptr) + i, NUM_REQ);
      if (!w_gnt_valid && !w_empty[idx]) begin
        w_gnt_valid = 1'b1;
        w_gnt       = SRC_W'(idx);
        w_sel_tag   = w_head_tag[idx];
        w_sel_data  = w_head_data[idx];
      end
    end
    w_rr_next = SRC_W'(rr_wrap(int'(w_gnt) + 1, NUM_REQ));
  end

  // Selection values default to zero, so an idle cycle clears the broadcast too.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_en     <= 1'b0;
      r_tag    <= '0;
      r_data   <= '0;
      r_src    <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_en   <= w_gnt_valid;
      r_tag  <= w_sel_tag;
      r_data <= w_sel_data;
      r_src  <= w_gnt;
      if (w_gnt_valid) r_rr_ptr <= w_rr_next;
    end
  end

  assign cdb_en   = r_en;
  assign cdb_tag  = r_tag;
  assign cdb_data = r_data;
  assign cdb_src  = r_src;

endmodule
